// File: rtl/status_reg.sv
// 6502 processor status register: flag updates, PLP/PHP formatting,
// NMI edge latching and IRQ polling.
module status_reg (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] res_i,
  input  logic       carry_i,
  input  logic       overflow_i,
  input  logic       upd_nz_i,
  input  logic       upd_c_i,
  input  logic       upd_v_i,
  input  logic       bit_i,
  input  logic       flag_wr_i,
  input  logic [2:0] flag_sel_i,
  input  logic       flag_val_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       brk_i,
  input  logic       nmi_i,
  input  logic       irq_i,
  input  logic       poll_i,
  input  logic       nmi_ack_i,
  output logic [7:0] p_o,
  output logic [7:0] p_push_o,
  output logic       carry_o,
  output logic       nmi_pending_o,
  output logic       irq_pending_o
);

  logic r_n, r_v, r_d, r_i, r_z, r_c;
  logic r_nmi_prev, r_nmi_latch, r_irq_pend;

  logic w_n, w_v, w_d, w_i, w_z, w_c;
  logic w_nmi_latch, w_irq_pend;
  logic w_res_zero;
  logic w_wr_c, w_wr_i, w_wr_d, w_wr_v;

  assign w_res_zero = (res_i == 8'h00);
  assign w_wr_c     = flag_wr_i && (flag_sel_i == 3'd0);
  assign w_wr_i     = flag_wr_i && (flag_sel_i == 3'd2);
  assign w_wr_d     = flag_wr_i && (flag_sel_i == 3'd3);
  assign w_wr_v     = flag_wr_i && (flag_sel_i == 3'd6);

  // Each flag resolves its own priority chain so that independent sources
  // targeting different flags in the same cycle all land.
  always_comb begin
    w_n = r_n;
    w_v = r_v;
    w_d = r_d;
    w_i = r_i;
    w_z = r_z;
    w_c = r_c;

    if (load_i)        w_n = data_i[7];
    else if (bit_i)    w_n = data_i[7];
    else if (upd_nz_i) w_n = res_i[7];

    if (load_i)        w_v = data_i[6];
    else if (w_wr_v)   w_v = flag_val_i;
    else if (bit_i)    w_v = data_i[6];
    else if (upd_v_i)  w_v = overflow_i;

    if (load_i)        w_d = data_i[3];
    else if (w_wr_d)   w_d = flag_val_i;

    if (load_i)        w_i = data_i[2];
    else if (w_wr_i)   w_i = flag_val_i;

    if (load_i)        w_z = data_i[1];
    else if (bit_i)    w_z = w_res_zero;
    else if (upd_nz_i) w_z = w_res_zero;

    if (load_i)        w_c = data_i[0];
    else if (w_wr_c)   w_c = flag_val_i;
    else if (upd_c_i)  w_c = carry_i;
  end

  // A fresh edge beats a simultaneous ack so a back-to-back NMI is not lost.
  always_comb begin
    w_nmi_latch = r_nmi_latch;
    if (nmi_i && !r_nmi_prev) w_nmi_latch = 1'b1;
    else if (nmi_ack_i)       w_nmi_latch = 1'b0;
  end

  // Poll uses the pre-write I, so CLI/SEI in the poll cycle affect the next poll.
  always_comb begin
    w_irq_pend = r_irq_pend;
    if (poll_i) w_irq_pend = irq_i && !r_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_n         <= 1'b0;
      r_v         <= 1'b0;
      r_d         <= 1'b0;
      r_i         <= 1'b1;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_nmi_prev  <= 1'b0;
      r_nmi_latch <= 1'b0;
      r_irq_pend  <= 1'b0;
    end else begin
      r_n         <= w_n;
      r_v         <= w_v;
      r_d         <= w_d;
      r_i         <= w_i;
      r_z         <= w_z;
      r_c         <= w_c;
      r_nmi_prev  <= nmi_i;
      r_nmi_latch <= w_nmi_latch;
      r_irq_pend  <= w_irq_pend;
    end
  end

  assign p_o           = {r_n, r_v, 1'b1, 1'b0, r_d, r_i, r_z, r_c};
  assign p_push_o      = {r_n, r_v, 1'b1, brk_i, r_d, r_i, r_z, r_c};
  assign carry_o       = r_c;
  assign nmi_pending_o = r_nmi_latch;
  assign irq_pending_o = r_irq_pend;

endmodule
